// File: rtl/layer_gen.sv
// Fully-parallel dense layer: NN lanes multiply-accumulate a NUM_WEIGHT-sample stream, add bias, activate, saturate.
// Last accepted sample in cycle T -> o_valid in T+3; result held until o_ready, x_ready low from last sample to handoff.
module layer_gen #(
  parameter int NN               = 10,
  parameter int NUM_WEIGHT       = 30,
  parameter int DATA_WIDTH       = 16,
  parameter int WEIGHT_INT_WIDTH = 4,
  parameter int LAYER_NUM        = 1,
  parameter     ACT_TYPE         = "relu"
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     weightValid,
  input  logic                     biasValid,
  input  logic [31:0]              weightValue,
  input  logic [31:0]              biasValue,
  input  logic [31:0]              config_layer_num,
  input  logic [31:0]              config_neuron_num,
  input  logic                     x_valid,
  input  logic [DATA_WIDTH-1:0]    x_in,
  output logic                     x_ready,
  output logic                     o_valid,
  output logic [NN*DATA_WIDTH-1:0] x_out,
  input  logic                     o_ready
);
  localparam int  W    = DATA_WIDTH;
  localparam int  F    = DATA_WIDTH - WEIGHT_INT_WIDTH;
  localparam int  AW   = 2 * DATA_WIDTH;
  localparam int  IW   = (NUM_WEIGHT > 1) ? $clog2(NUM_WEIGHT) : 1;
  localparam int  NW   = (NN > 1) ? $clog2(NN) : 1;
  localparam bit  RELU = (ACT_TYPE == "relu");
  localparam logic signed [AW-1:0] MAXV = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = {{(W+1){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HOLD} state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic                   drain_q;
  logic                   pvld_q;
  logic signed [AW-1:0]   prod_q [NN];
  logic signed [AW-1:0]   acc_q  [NN];
  logic [W-1:0]           x_out_q [NN];
  logic [W-1:0]           weight_q [NN][NUM_WEIGHT];
  logic [W-1:0]           bias_q [NN];
  logic [IW-1:0]          wptr_q [NN];

  logic          accept, last_idx, cfg_hit, w_wr, b_wr;
  logic [NW-1:0] wr_lane;
  logic          unused_hi;

  assign accept   = x_valid & x_ready;
  assign last_idx = (idx_q == IW'(NUM_WEIGHT - 1));
  assign cfg_hit  = ~rst && (state_q == IDLE) && (config_layer_num == 32'(LAYER_NUM))
                    && (config_neuron_num < 32'(NN));
  assign w_wr     = weightValid & cfg_hit;
  assign b_wr     = biasValid & cfg_hit;
  assign wr_lane  = config_neuron_num[NW-1:0];
  assign unused_hi = ^{weightValue[31:W], biasValue[31:W]};

  function automatic logic [W-1:0] act_sat(input logic signed [AW-1:0] s);
    logic signed [AW-1:0] v;
    v = (RELU && s < 0) ? '0 : s;
    if (v > MAXV)      v = MAXV;
    else if (v < MINV) v = MINV;
    return v[W-1:0];
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      drain_q <= (state_q == DRAIN) && !drain_q;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (accept) idx_d = last_idx ? '0 : idx_q + 1'b1;
    case (state_q)
      IDLE:  if (accept) state_d = last_idx ? DRAIN : RUN;
      RUN:   if (accept && last_idx) state_d = DRAIN;
      DRAIN: if (drain_q) state_d = HOLD;
      HOLD:  if (o_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    x_ready = (state_q == IDLE) || (state_q == RUN);
    o_valid = (state_q == HOLD);
  end

  // Datapath: product stage, accumulate stage, bias/activation into the output register
  always_ff @(posedge clk) begin
    if (rst) begin
      pvld_q <= 1'b0;
      for (int n = 0; n < NN; n++) begin
        prod_q[n]  <= '0;
        acc_q[n]   <= '0;
        x_out_q[n] <= '0;
        wptr_q[n]  <= '0;
      end
    end else begin
      pvld_q <= accept;
      for (int n = 0; n < NN; n++) begin
        if (accept)
          prod_q[n] <= $signed({{W{x_in[W-1]}}, x_in})
                     * $signed({{W{weight_q[n][idx_q][W-1]}}, weight_q[n][idx_q]});
        if (accept && state_q == IDLE)
          acc_q[n] <= '0;
        else if (pvld_q)
          acc_q[n] <= acc_q[n] + (prod_q[n] >>> F);
        if (state_q == DRAIN && drain_q)
          x_out_q[n] <= act_sat(acc_q[n] + $signed({{W{bias_q[n][W-1]}}, bias_q[n]}));
      end
      if (w_wr)
        wptr_q[wr_lane] <= (wptr_q[wr_lane] == IW'(NUM_WEIGHT - 1)) ? '0 : wptr_q[wr_lane] + 1'b1;
    end
  end

  // Coefficient storage survives reset
  always_ff @(posedge clk) begin
    if (w_wr) weight_q[wr_lane][wptr_q[wr_lane]] <= weightValue[W-1:0];
    if (b_wr) bias_q[wr_lane] <= biasValue[W-1:0];
  end

  for (genvar g = 0; g < NN; g++) begin : g_out
    assign x_out[g*W +: W] = x_out_q[g];
  end
endmodule

// File: doc/layer_gen.md
LAYER_GEN -- requirements
Module: layer_gen

Interface
REQ-001 SHALL have parameter NN, default 10, number of parallel neuron lanes.
REQ-002 SHALL have parameter NUM_WEIGHT, default 30, inputs per inference and weights per lane.
REQ-003 SHALL have parameter DATA_WIDTH, default 16, signed two's-complement width of data, weights and biases.
REQ-004 SHALL have parameter WEIGHT_INT_WIDTH, default 4, integer bits (incl. sign); fraction bits F = DATA_WIDTH-WEIGHT_INT_WIDTH.
REQ-005 SHALL have parameter LAYER_NUM, default 1, layer id matched against config_layer_num.
REQ-006 SHALL have parameter ACT_TYPE, default "relu"; legal values "relu" and "none".
REQ-007 Ports: clk  in  1  rising-edge clock; the only clock.
REQ-008 rst  in  1  reset; synchronous, active-high.
REQ-009 weightValid  in  1  weight write strobe; biasValid  in  1  bias write strobe.
REQ-010 weightValue, biasValue  in  32 each  write data; bits [DATA_WIDTH-1:0] used.
REQ-011 config_layer_num, config_neuron_num  in  32 each  write target layer / lane.
REQ-012 x_valid  in  1;  x_in  in  DATA_WIDTH;  x_ready  out  1  input stream handshake.
REQ-013 o_valid  out  1;  x_out  out  NN*DATA_WIDTH, lane n at [n*DATA_WIDTH +: DATA_WIDTH];  o_ready  in  1.

Function
REQ-014 FSM states IDLE, RUN, DRAIN, HOLD; x_ready SHALL be 1 in IDLE and RUN, 0 in DRAIN and HOLD.
REQ-015 Sample accepted when x_valid & x_ready; input index counter 0..NUM_WEIGHT-1 advances per acceptance.
REQ-016 IDLE -> RUN on first acceptance; RUN -> DRAIN on acceptance of index NUM_WEIGHT-1 (NUM_WEIGHT=1: IDLE -> DRAIN directly).
REQ-017 Each lane n: product of x_in and weight[n][index], full 2*DATA_WIDTH signed, registered one cycle after acceptance.
REQ-018 Registered product arithmetic-shifted right by F, added to 2*DATA_WIDTH-bit signed accumulator the following cycle; accumulator cleared at start of every inference.
REQ-019 DRAIN lasts exactly 2 cycles: pipeline flush, then accumulator + sign-extended bias[n] → activation → saturation registered into x_out; then HOLD.
REQ-020 Activation: "relu" maps negative sums to 0; "none" passes through; then saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-021 Latency: last sample accepted in cycle T -> o_valid high in cycle T+3.
REQ-022 o_valid =1 exactly in HOLD; x_out stable while o_valid & ~o_ready; HOLD -> IDLE on o_valid & o_ready; next sample acceptable the following cycle.
REQ-023 x_valid ignored when x_ready=0; gaps in x_valid stall counter and pipeline without corrupting sums.
REQ-024 Weight write: weightValid & config_layer_num==LAYER_NUM & config_neuron_num<NN & state IDLE writes weight[config_neuron_num][wptr[lane]], then wptr[lane] increments, wrapping NUM_WEIGHT-1 -> 0.
REQ-025 Bias write: same qualification with biasValid, writes bias[config_neuron_num]; simultaneous weight and bias strobes both take effect.
REQ-026 Writes with non-matching layer, out-of-range neuron, or state not IDLE SHALL be dropped with no state change.
REQ-027 Write in the same cycle as first sample acceptance SHALL take effect; weights are read starting the next accepted sample.

Reset
REQ-028 rst SHALL force state IDLE, index counter 0, accumulators 0, pipeline registers 0, o_valid 0, x_out 0, all wptr 0; x_ready 1 after reset.
REQ-029 Weight and bias storage SHALL NOT be cleared by rst.
REQ-030 rst asserted mid-inference (any state) SHALL abort it; no o_valid for the aborted inference.

Verification (NN=2, NUM_WEIGHT=4, DATA_WIDTH=16, WEIGHT_INT_WIDTH=4, LAYER_NUM=1)
REQ-031 Load lane0 weights 0x1000 x4, bias 0; lane1 weights 0xF000 x4, bias 0x0800; stream 0x0800 x4 back-to-back -> o_valid in T+3; lane0=0x2000, lane1=0x0000 (relu).
REQ-032 Same with ACT_TYPE="none" -> lane1=0xE800.
REQ-033 Lane0 weights 0x7000, inputs 0x7000 x4 -> lane0=0x7FFF (saturated); negative mirror with ACT_TYPE="none" -> 0x8000.
REQ-034 o_ready held 0 for 5 cycles at HOLD -> x_out stable, x_ready 0, x_valid ignored; o_ready 1 -> IDLE next cycle.
REQ-035 Weight write with config_layer_num=2, and any write during RUN -> results unchanged from REQ-031.
REQ-036 rst pulsed after 2 accepted samples -> no o_valid; fresh 4-sample inference yields REQ-031 values.
